// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the instruction/data RAM port arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, MEM-stage and RAM-macro signals around the arbiter.
// slave  : the arbiter itself
// master : the surrounding pipeline stages and RAM macro
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    localparam int BE_W = DATA_W / 8;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic [BE_W-1:0]   d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic              ram_en;
    logic [BE_W-1:0]   ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic              busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        output i_ack, i_rdata, d_ack, d_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata, busy
    );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of arbitrations fetch lost to the data port.
// Only present when ARB_STARVE_GUARD_EN is defined.
`ifdef ARB_STARVE_GUARD_EN
module arb_starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);
    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign sat_o = (cnt_q >= CNT_W'(LIMIT));

    // Clear wins over increment; hold once the limit is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !sat_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port RAM between fetch (read-only) and the MEM stage.
// Data port has priority. Defining ARB_STARVE_GUARD_EN adds a counter that
// forces a fetch grant after STARVE_LIMIT lost arbitrations.
//
// state  | meaning
// IDLE   | no access in flight, arbitrate on this edge
// ACCESS | RAM strobed with the latched request
// RESP   | one-cycle ack to the owner, read data passed from the RAM
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int BE_W = DATA_W / 8;

    if (STARVE_LIMIT < 1) begin : g_limit_chk
        $error("STARVE_LIMIT must be at least 1");
    end

    arb_state_e        state_q;
    arb_owner_e        owner_q;
    logic              load_q;
    logic              ram_en_q;
    logic [BE_W-1:0]   ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic              i_ack_q;
    logic              d_ack_q;

    logic              grant_d;
    logic              starve_ovr;

`ifdef ARB_STARVE_GUARD_EN
    logic arb_idle;
    logic starve_sat;

    assign arb_idle = (state_q == IDLE);

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk   (clk),
        .rst   (rst),
        .inc_i (arb_idle && bus.i_req && grant_d),
        .clr_i (arb_idle && bus.i_req && !grant_d),
        .sat_o (starve_sat)
    );

    assign starve_ovr = starve_sat && bus.i_req;
`else
    assign starve_ovr = 1'b0;
`endif

    assign grant_d = bus.d_req && !starve_ovr;

    // Arbitration FSM; all RAM-side and ack outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_I;
            load_q      <= 1'b1;
            ram_en_q    <= 1'b0;
            ram_we_q    <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    i_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                    if (grant_d) begin
                        state_q     <= ACCESS;
                        owner_q     <= OWN_D;
                        load_q      <= (bus.d_we == '0);
                        ram_en_q    <= 1'b1;
                        ram_we_q    <= bus.d_we;
                        ram_addr_q  <= bus.d_addr;
                        ram_wdata_q <= bus.d_wdata;
                    end else if (bus.i_req) begin
                        // Fetch leaves ram_wdata at its previous value.
                        state_q    <= ACCESS;
                        owner_q    <= OWN_I;
                        load_q     <= 1'b1;
                        ram_en_q   <= 1'b1;
                        ram_we_q   <= '0;
                        ram_addr_q <= bus.i_addr;
                    end
                end
                ACCESS: begin
                    state_q  <= RESP;
                    ram_en_q <= 1'b0;
                    ram_we_q <= '0;
                    i_ack_q  <= (owner_q == OWN_I);
                    d_ack_q  <= (owner_q == OWN_D);
                end
                RESP: begin
                    state_q <= IDLE;
                    i_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    i_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                end
            endcase
        end
    end

    // RAM data arrives the cycle after the strobe, i.e. during RESP, so the
    // read data is steered combinationally and gated by the registered ack.
    assign bus.i_rdata   = i_ack_q ? bus.ram_rdata : '0;
    assign bus.d_rdata   = (d_ack_q && load_q) ? bus.ram_rdata : '0;
    assign bus.i_ack     = i_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.ram_en    = ram_en_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int BW    = DW / 8;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst;
    logic ram_init;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural RAM macro: read-old-data, byte write enables.
    logic [DW-1:0] ram_mem   [0:255];
    logic [DW-1:0] model_mem [0:255];

    always @(posedge clk) begin
        if (ram_init) begin
            ram_mem <= model_mem;
        end else if (bus.ram_en) begin
            bus.ram_rdata <= ram_mem[bus.ram_addr];
            for (int b = 0; b < BW; b++) begin
                if (bus.ram_we[b]) ram_mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
            end
        end
    end

    int tests = 0;
    int fails = 0;

    // Reference model: transaction timing from the grant edge number.
    int          cyc        = 0;
    int          free_k     = 0;
    int          access_cyc = -1;
    int          ack_cyc    = -1;
    int          starve_cnt = 0;
    logic        m_own_d    = 1'b0;
    logic [BW-1:0] m_we     = '0;
    logic [AW-1:0] m_addr_last  = '0;
    logic [DW-1:0] m_wdata_last = '0;
    logic [DW-1:0] m_rdata      = '0;
    bit          last_ia = 1'b0;
    bit          last_da = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit en_e, ia_e, da_e, pick_i, guard_win;
        if (rst) begin
            starve_cnt   = 0;
            free_k       = cyc + 1;
            access_cyc   = -1;
            ack_cyc      = -1;
            m_addr_last  = '0;
            m_wdata_last = '0;
        end else if (cyc >= free_k && (bus.i_req || bus.d_req)) begin
            guard_win = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
            guard_win = bus.i_req && (starve_cnt >= LIMIT);
`endif
            pick_i = !bus.d_req || guard_win;
            if (bus.i_req) starve_cnt = pick_i ? 0 : ((starve_cnt < LIMIT) ? starve_cnt + 1 : LIMIT);
            access_cyc = cyc + 1;
            ack_cyc    = cyc + 2;
            free_k     = cyc + 3;
            m_own_d    = !pick_i;
            if (pick_i) begin
                m_addr_last = bus.i_addr;
                m_we        = '0;
                m_rdata     = model_mem[bus.i_addr];
            end else begin
                m_addr_last  = bus.d_addr;
                m_we         = bus.d_we;
                m_wdata_last = bus.d_wdata;
                m_rdata      = (bus.d_we == '0) ? model_mem[bus.d_addr] : '0;
                for (int b = 0; b < BW; b++) begin
                    if (bus.d_we[b]) model_mem[bus.d_addr][8*b +: 8] = bus.d_wdata[8*b +: 8];
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        en_e = (cyc == access_cyc);
        ia_e = (cyc == ack_cyc) && !m_own_d;
        da_e = (cyc == ack_cyc) && m_own_d;
        chk("busy",      64'(bus.busy),      64'(cyc < free_k));
        chk("ram_en",    64'(bus.ram_en),    64'(en_e));
        chk("ram_we",    64'(bus.ram_we),    64'(en_e ? m_we : '0));
        chk("ram_addr",  64'(bus.ram_addr),  64'(m_addr_last));
        chk("ram_wdata", 64'(bus.ram_wdata), 64'(m_wdata_last));
        chk("i_ack",     64'(bus.i_ack),     64'(ia_e));
        chk("d_ack",     64'(bus.d_ack),     64'(da_e));
        chk("i_rdata",   64'(bus.i_rdata),   64'(ia_e ? m_rdata : '0));
        chk("d_rdata",   64'(bus.d_rdata),   64'(da_e ? m_rdata : '0));
        chk("ack_excl",  64'(bus.i_ack & bus.d_ack), 64'(0));
        last_ia = ia_e;
        last_da = da_e;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic run_until(input bit want_d, input int budget, output int at);
        at = -1;
        for (int n = 0; n < budget; n++) begin
            step();
            if (want_d ? last_da : last_ia) begin
                at = cyc;
                break;
            end
        end
        chk(want_d ? "d_ack_timeout" : "i_ack_timeout", 64'(at >= 0), 64'(1));
    endtask

    initial begin
        int s, at, da_at, ia_at, seen;
        rst = 1'b1;
        ram_init = 1'b0;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = '0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.ram_rdata = '0;
        for (int a = 0; a < 256; a++) model_mem[a] = $urandom;
        model_mem[8'h10] = 32'hDEAD_BEEF;
        model_mem[8'h05] = 32'h1122_3344;
        ram_init = 1'b1;
        step();
        ram_init = 1'b0;
        step();
        rst = 1'b0;

        // Fetch read
        bus.i_req = 1'b1; bus.i_addr = 8'h10;
        s = cyc;
        step();
        chk("fetch_ram_en", 64'(bus.ram_en), 64'(1));
        step();
        chk("fetch_ack_cycle", 64'(cyc - s), 64'(2));
        chk("fetch_ack", 64'(bus.i_ack), 64'(1));
        chk("fetch_data", 64'(bus.i_rdata), 64'(32'hDEAD_BEEF));
        bus.i_req = 1'b0;
        step();
        chk("fetch_busy_after", 64'(bus.busy), 64'(0));

        // Partial store then load
        bus.d_req = 1'b1; bus.d_we = 4'b0011; bus.d_addr = 8'h05; bus.d_wdata = 32'h0000_ABCD;
        s = cyc;
        run_until(1'b1, 6, at);
        chk("store_ack_cycle", 64'(at - s), 64'(2));
        chk("store_rdata_zero", 64'(bus.d_rdata), 64'(0));
        bus.d_we = 4'b0000;
        run_until(1'b1, 8, at);
        chk("load_after_store", 64'(bus.d_rdata), 64'(32'h1122_ABCD));
        bus.d_req = 1'b0;
        step();

        // Contention from a clean counter
        do_reset(1);
        bus.i_req = 1'b1; bus.i_addr = 8'h03;
        bus.d_req = 1'b1; bus.d_we = '0; bus.d_addr = 8'h07;
        s = cyc; da_at = -1; ia_at = -1;
        for (int n = 0; n < 12; n++) begin
            step();
            if (last_da) begin da_at = cyc; bus.d_req = 1'b0; end
            if (last_ia) begin ia_at = cyc; bus.i_req = 1'b0; end
        end
        chk("cont_d_at", 64'(da_at - s), 64'(2));
        chk("cont_i_at", 64'(ia_at - s), 64'(5));

        // Starvation behaviour with back-to-back data loads
        do_reset(1);
        bus.i_req = 1'b1; bus.i_addr = 8'h02;
        bus.d_req = 1'b1; bus.d_we = '0; bus.d_addr = 8'h04;
        s = cyc;
`ifdef ARB_STARVE_GUARD_EN
        ia_at = -1;
        for (int n = 0; n < 20 && ia_at < 0; n++) begin
            step();
            if (last_da) bus.d_addr = 8'($urandom_range(15, 0));
            if (last_ia) ia_at = cyc;
        end
        chk("starve_i_at", 64'(ia_at - s), 64'(14));
        ia_at = -1;
        for (int n = 0; n < 20 && ia_at < 0; n++) begin
            step();
            if (last_da) bus.d_addr = 8'($urandom_range(15, 0));
            if (last_ia) ia_at = cyc;
        end
        chk("starve_rearm_at", 64'(ia_at - s), 64'(29));
`else
        seen = 0;
        for (int n = 0; n < 24; n++) begin
            step();
            if (bus.i_ack) seen++;
            if (last_da) bus.d_addr = 8'($urandom_range(15, 0));
        end
        chk("strict_prio_i_starved", 64'(seen), 64'(0));
        bus.d_req = 1'b0;
        run_until(1'b0, 8, at);
`endif
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        repeat (3) step();

        // Reset during ACCESS of a fetch
        bus.i_req = 1'b1; bus.i_addr = 8'h10;
        step();
        chk("rst_acc_in_access", 64'(bus.ram_en), 64'(1));
        rst = 1'b1; bus.i_req = 1'b0;
        step();
        rst = 1'b0;
        chk("rst_acc_busy", 64'(bus.busy), 64'(0));
        chk("rst_acc_ram_en", 64'(bus.ram_en), 64'(0));
        seen = 0;
        repeat (5) begin step(); if (bus.i_ack) seen++; end
        chk("rst_acc_no_ack", 64'(seen), 64'(0));

        // Idle
        seen = 0;
        repeat (10) begin
            step();
            if (bus.ram_en || bus.i_ack || bus.d_ack || bus.busy) seen++;
        end
        chk("idle_quiet", 64'(seen), 64'(0));

        // Randomized traffic with occasional resets
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(63, 0) == 0);
            if (!bus.i_req || last_ia) begin
                bus.i_req  = ($urandom_range(1, 0) == 1);
                bus.i_addr = 8'($urandom_range(15, 0));
            end
            if (!bus.d_req || last_da) begin
                bus.d_req   = ($urandom_range(1, 0) == 1);
                bus.d_we    = ($urandom_range(1, 0) == 1) ? 4'b0000 : 4'($urandom_range(15, 1));
                bus.d_addr  = 8'($urandom_range(15, 0));
                bus.d_wdata = $urandom;
            end
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port synchronous data/instruction RAM between two requesters: the fetch stage (read-only) and the MEM stage (loads and stores, byte enables).
- Sits between the pipeline stages and the RAM macro. It replaces the per-stage ad-hoc mreq/mres handshake with a registered req/ack protocol.
- Data port has priority; fetch is protected from starvation when the optional guard is compiled in.

Parameters:
- ADDR_W, 8, word-address width (RAM depth 2^ADDR_W words)
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- STARVE_LIMIT, 4, lost arbitrations after which fetch wins (used only with the guard)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- i_req  input  1  fetch request; held until i_ack
- i_addr  input  ADDR_W  fetch word address
- i_ack  output  1  one-cycle completion pulse to fetch
- i_rdata  output  DATA_W  fetch read data, valid while i_ack=1
- d_req  input  1  MEM-stage request; held until d_ack
- d_we  input  DATA_W/8  byte enables; 0 = load, nonzero = store
- d_addr  input  ADDR_W  data word address
- d_wdata  input  DATA_W  store data (byte lanes already aligned)
- d_ack  output  1  one-cycle completion pulse to MEM stage
- d_rdata  output  DATA_W  load data, valid while d_ack=1 on a load
- ram_en  output  1  RAM access strobe
- ram_we  output  DATA_W/8  RAM byte write enables
- ram_addr  output  ADDR_W  RAM word address
- ram_wdata  output  DATA_W  RAM write data
- ram_rdata  input  DATA_W  RAM read data, one cycle after ram_en
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous, active-high.
- FSM states: IDLE, ACCESS, RESP.
- IDLE arbitration:
  - If d_req=1 (and the starvation override is not active), latch owner=D, d_addr, d_we, d_wdata; go to ACCESS.
  - Otherwise, if i_req=1, latch owner=I, i_addr, we=0; go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS (one cycle):
  - ram_en=1, ram_addr/ram_we/ram_wdata driven from the latched registers.
  - Always go to RESP.
- RESP (one cycle):
  - Ack of the owner = 1; the other ack = 0.
  - Owner rdata = ram_rdata on a load; 0 on a store or when not acked.
  - Always go to IDLE. No back-to-back grant from RESP: the requester drops or changes req on the ack edge.
- Latency: req sampled in IDLE at edge k -> ACCESS in cycle k+1 -> ack in cycle k+2. Peak throughput is 1 access per 3 cycles.
- Outside ACCESS: ram_en=0 and ram_we=0. ram_addr and ram_wdata hold their last values.
- Reset values: state=IDLE; ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0; i_ack=0, d_ack=0; i_rdata=0, d_rdata=0; busy=0; starvation count=0.
- Reset mid-operation (ACCESS or RESP): return to IDLE next cycle with no ack. If the transaction was in ACCESS, the RAM still samples that cycle, so a store may land; the requester must reissue.
- Requests changing while not in IDLE are ignored. Address and data are latched only at grant.
- Simultaneous i_req and d_req without the guard: D always wins. I is served on the next IDLE in which d_req=0.
- Ack is never asserted without a matching grant. Both acks are never high together.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- With the macro: a saturating counter increments on each IDLE arbitration where i_req=1 and D is granted.
  - When the count is >= STARVE_LIMIT, the next IDLE arbitration with i_req=1 grants I even if d_req=1.
  - The counter clears to 0 on any I grant.
- Without the macro: strict data priority; no counter logic is present.

Decomposition:
- Package mem_arb_pkg holds:
  - state encodings IDLE=2'd0, ACCESS=2'd1, RESP=2'd2
  - owner constants OWN_I=1'b0, OWN_D=1'b1
  - default ADDR_W and DATA_W
- One optional sub-module, arb_starve_counter (inc, clr, sat-compare output), instantiated only under ARB_STARVE_GUARD_EN.

Test Plan:
- Fetch read: RAM[0x10]=0xDEADBEEF; i_req=1, i_addr=0x10 at edge 0 -> ram_en=1 in cycle 1; i_ack=1, i_rdata=0xDEADBEEF in cycle 2; busy=0 in cycle 3.
- Partial store then load: d_we=4'b0011, d_addr=0x05, d_wdata=0x0000ABCD over RAM 0x11223344 -> d_ack in cycle 2; a following load of 0x05 returns 0x1122ABCD.
- Contention, guard off: i_req and d_req rise together -> d_ack at cycle 2, i_ack at cycle 5; never both high in the same cycle.
- Starvation, guard on, STARVE_LIMIT=4: d_req held high with back-to-back loads and i_req held high -> the fifth grant goes to I; i_ack asserts and the counter reads 0 afterwards.
- Reset in ACCESS: rst=1 during the ACCESS cycle of a fetch -> no i_ack ever; state=IDLE, ram_en=0, busy=0 the cycle after reset.
- Idle: no requests for 10 cycles -> ram_en=0, both acks 0, busy=0 throughout.
